// File: rtl/layer_seq_pkg.sv
// ============================================================================
// Module      : layer_seq_pkg
// Description : Shared state encoding and default sizing for the layer sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package layer_seq_pkg;

    localparam int DEF_TILE_W      = 8;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_TILE_BYTES  = 256;
    localparam int DEF_TIMEOUT_CYC = 4096;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/layer_sequencer_if.sv
// ============================================================================
// Module      : layer_sequencer_if
// Description : Tile start/done handshake between sequencer and compute engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface layer_sequencer_if
    import layer_seq_pkg::*;
#(
    parameter int TILE_W = DEF_TILE_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              eng_start;
    logic [TILE_W-1:0] eng_tile_idx;
    logic [ADDR_W-1:0] eng_addr;
    logic              eng_relu;
    logic              eng_done;

    modport master (
        output eng_start,
        output eng_tile_idx,
        output eng_addr,
        output eng_relu,
        input  eng_done
    );

    modport slave (
        input  eng_start,
        input  eng_tile_idx,
        input  eng_addr,
        input  eng_relu,
        output eng_done
    );

endinterface

`default_nettype wire

// File: rtl/seq_watchdog.sv
// ============================================================================
// Module      : seq_watchdog
// Description : Per-tile wait counter; expired asserts at TIMEOUT_CYC-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_watchdog
    import layer_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  wire  HCLK,
    input  wire  HRESETn,
    input  wire  clear,
    input  wire  enable,
    output logic expired
);

    localparam int               c_cnt_w = $clog2(TIMEOUT_CYC);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYC - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_expired;

    assign w_expired = (r_cnt == c_limit);
    assign expired   = w_expired;

    // Saturates at the limit so a late exit from WAIT never sees a wrapped count
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && !w_expired) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/layer_sequencer.sv
// ============================================================================
// Module      : layer_sequencer
// Description : Issues one layer of tiles to the engine on a trigger rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int TILE_W      = DEF_TILE_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int TILE_BYTES  = DEF_TILE_BYTES,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  wire                HCLK,
    input  wire                HRESETn,
    input  wire                read_trigger,
    input  wire                is_relu,
    input  wire                is_last,
    input  wire  [TILE_W-1:0]  num_tiles,
    input  wire  [ADDR_W-1:0]  base_addr,
    layer_sequencer_if.master  eng,
    output logic               busy,
    output logic               done_irq,
    output logic               layer_done,
    output logic               last_layer,
    output logic               err
);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic              r_trig_q;
    logic              w_start_ev;
    logic [TILE_W-1:0] r_num;
    logic [TILE_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_addr;
    logic              r_relu;
    logic              r_last;
    logic              r_layer_done;
    logic              r_last_layer;
    logic              r_err;
    logic              w_last_tile;
    logic              w_wd_expired;
    logic              w_eng_start;
    logic              w_busy;
    logic              w_done_irq;

    assign w_start_ev  = read_trigger & ~r_trig_q;
    assign w_last_tile = (r_idx == r_num - TILE_W'(1));

    seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .clear   (r_state == ST_ISSUE),
        .enable  (r_state == ST_WAIT),
        .expired (w_wd_expired)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A done pulse takes priority over a watchdog expiry in the same cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ev) begin
                    w_next_state = (num_tiles == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (eng.eng_done) begin
                    w_next_state = w_last_tile ? ST_DONE : ST_ISSUE;
                end else if (w_wd_expired) begin
                    w_next_state = ST_ERROR;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            ST_ERROR: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_eng_start = 1'b0;
        w_busy      = 1'b1;
        w_done_irq  = 1'b0;
        case (r_state)
            ST_IDLE:  w_busy      = 1'b0;
            ST_ISSUE: w_eng_start = 1'b1;
            ST_DONE:  w_done_irq  = 1'b1;
            default:  ;
        endcase
    end

    // Run parameters are snapshotted on the accepted edge so mid-run input changes are ignored
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_trig_q     <= 1'b0;
            r_num        <= '0;
            r_idx        <= '0;
            r_addr       <= '0;
            r_relu       <= 1'b0;
            r_last       <= 1'b0;
            r_layer_done <= 1'b0;
            r_last_layer <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_trig_q <= read_trigger;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ev) begin
                        r_num        <= num_tiles;
                        r_idx        <= '0;
                        r_addr       <= base_addr;
                        r_relu       <= is_relu;
                        r_last       <= is_last;
                        r_layer_done <= 1'b0;
                        r_last_layer <= 1'b0;
                        r_err        <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (eng.eng_done && !w_last_tile) begin
                        r_idx  <= r_idx + TILE_W'(1);
                        r_addr <= r_addr + ADDR_W'(TILE_BYTES);
                    end
                end
                ST_DONE: begin
                    r_layer_done <= 1'b1;
                    r_last_layer <= r_last;
                end
                ST_ERROR: r_err <= 1'b1;
                default:  ;
            endcase
        end
    end

    assign eng.eng_start    = w_eng_start;
    assign eng.eng_tile_idx = r_idx;
    assign eng.eng_addr     = r_addr;
    assign eng.eng_relu     = r_relu;
    assign busy             = w_busy;
    assign done_irq         = w_done_irq;
    assign layer_done       = r_layer_done;
    assign last_layer       = r_last_layer;
    assign err              = r_err;

endmodule

`default_nettype wire

// File: tb/tb_layer_sequencer.sv
// ============================================================================
// Module      : tb_layer_sequencer
// Description : Directed bench with an event-timeline model of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_layer_sequencer;

    localparam int TILE_W     = 8;
    localparam int ADDR_W     = 32;
    localparam int TILE_BYTES = 256;
    localparam int TOUT       = 16;

    typedef struct {
        int          cyc;
        logic [7:0]  idx;
        logic [31:0] addr;
        logic        relu;
    } start_t;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        read_trigger = 1'b0;
    logic        is_relu = 1'b0;
    logic        is_last = 1'b0;
    logic [7:0]  num_tiles = '0;
    logic [31:0] base_addr = '0;
    logic        busy, done_irq, layer_done, last_layer, err;

    layer_sequencer_if #(.TILE_W(TILE_W), .ADDR_W(ADDR_W)) eng_if ();

    layer_sequencer #(
        .TILE_W      (TILE_W),
        .ADDR_W      (ADDR_W),
        .TILE_BYTES  (TILE_BYTES),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .read_trigger (read_trigger),
        .is_relu      (is_relu),
        .is_last      (is_last),
        .num_tiles    (num_tiles),
        .base_addr    (base_addr),
        .eng          (eng_if.master),
        .busy         (busy),
        .done_irq     (done_irq),
        .layer_done   (layer_done),
        .last_layer   (last_layer),
        .err          (err)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected event timeline
    start_t      exp_q[$];
    int          irq_q[$];
    int          bf = 1;
    int          bt = 0;
    logic [31:0] obs_addr[$];
    logic [7:0]  obs_idx[$];
    int          irq_seen = 0;

    // Engine model: done pulse resp_lat cycles after a start; negative = never
    int resp_lat = 2;
    int due = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Timeline of a run whose accepted edge is in cycle p
    task automatic predict(input int p, input int num, input logic [31:0] base,
                           input logic relu, input int lat);
        start_t s;
        int per = lat + 1;
        bf = p + 1;
        if (num == 0) begin
            irq_q.push_back(p + 1);
            bt = p + 1;
        end else if (lat < 0) begin
            s.cyc = p + 1; s.idx = 8'd0; s.addr = base; s.relu = relu;
            exp_q.push_back(s);
            bt = p + TOUT + 2;
        end else begin
            for (int k = 0; k < num; k++) begin
                s.cyc  = p + 1 + k * per;
                s.idx  = 8'(k);
                s.addr = base + 32'(k * TILE_BYTES);
                s.relu = relu;
                exp_q.push_back(s);
            end
            irq_q.push_back(p + 1 + num * per);
            bt = p + 1 + num * per;
        end
    endtask

    always @(negedge HCLK) begin
        if (HRESETn && eng_if.eng_start && resp_lat > 0) due = cyc + resp_lat;
    end

    initial begin
        eng_if.eng_done = 1'b0;
        forever begin
            @(posedge HCLK);
            #1;
            eng_if.eng_done = HRESETn && (cyc == due);
        end
    end

    // Compare process
    always @(negedge HCLK) begin
        if (HRESETn) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                fail("start_missing", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            while (irq_q.size() > 0 && irq_q[0] < cyc) begin
                fail("irq_missing", cyc, irq_q[0]);
                void'(irq_q.pop_front());
            end
            if (eng_if.eng_start) begin
                if (exp_q.size() == 0) begin
                    fail("start_unexpected", 1, 0);
                end else begin
                    check("start_cyc", 64'(cyc), 64'(exp_q[0].cyc));
                    check("tile_idx", 64'(eng_if.eng_tile_idx), 64'(exp_q[0].idx));
                    check("tile_addr", 64'(eng_if.eng_addr), 64'(exp_q[0].addr));
                    check("relu", 64'(eng_if.eng_relu), 64'(exp_q[0].relu));
                    void'(exp_q.pop_front());
                end
                obs_idx.push_back(eng_if.eng_tile_idx);
                obs_addr.push_back(eng_if.eng_addr);
            end
            if (done_irq) begin
                irq_seen++;
                if (irq_q.size() == 0) begin
                    fail("irq_unexpected", 1, 0);
                end else begin
                    check("irq_cyc", 64'(cyc), 64'(irq_q[0]));
                    void'(irq_q.pop_front());
                end
            end
            check("busy", 64'(busy), 64'((cyc >= bf) && (cyc <= bt)));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_idx.delete();
        irq_seen = 0;
    endtask

    task automatic start_run(input int num, input logic [31:0] base, input logic relu,
                             input logic last, input int lat);
        num_tiles    = 8'(num);
        base_addr    = base;
        is_relu      = relu;
        is_last      = last;
        resp_lat     = lat;
        read_trigger = 1'b1;
        predict(cyc, num, base, relu, lat);
        wait_cyc(1);
        read_trigger = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || irq_q.size() != 0 || cyc <= bt) && n < budget) begin
            wait_cyc(1);
            n++;
        end
        if (n >= budget) fail("idle_timeout", n, budget);
        wait_cyc(2);
    endtask

    initial begin
        #1000000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge HCLK);
        #3;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(eng_if.eng_start), 64'd0);
        check("rst_done_flags", 64'({layer_done, last_layer, err, done_irq}), 64'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        wait_cyc(2);

        // Basic run, inputs scrambled mid-run
        clear_obs();
        start_run(3, 32'h1000, 1'b1, 1'b0, 2);
        num_tiles = 8'd9; base_addr = 32'hDEAD0000; is_relu = 1'b0; is_last = 1'b1;
        wait_idle(200);
        check("basic_nstarts", 64'(obs_addr.size()), 64'd3);
        if (obs_addr.size() == 3) begin
            check("basic_addr0", 64'(obs_addr[0]), 64'h1000);
            check("basic_addr1", 64'(obs_addr[1]), 64'h1100);
            check("basic_addr2", 64'(obs_addr[2]), 64'h1200);
            check("basic_idx2", 64'(obs_idx[2]), 64'd2);
        end
        check("basic_irqs", 64'(irq_seen), 64'd1);
        check("basic_layer_done", 64'(layer_done), 64'd1);
        check("basic_last_layer", 64'(last_layer), 64'd0);
        check("basic_busy", 64'(busy), 64'd0);

        // Zero tiles
        clear_obs();
        start_run(0, 32'h2000, 1'b0, 1'b1, 2);
        wait_idle(50);
        check("zero_nstarts", 64'(obs_addr.size()), 64'd0);
        check("zero_irqs", 64'(irq_seen), 64'd1);
        check("zero_layer_done", 64'(layer_done), 64'd1);
        check("zero_last_layer", 64'(last_layer), 64'd1);

        // Retrigger during WAIT of tile 1
        clear_obs();
        start_run(4, 32'h4000, 1'b1, 1'b0, 2);
        wait_cyc(4);
        read_trigger = 1'b1;
        wait_cyc(1);
        read_trigger = 1'b0;
        wait_idle(200);
        check("retrig_nstarts", 64'(obs_addr.size()), 64'd4);
        check("retrig_irqs", 64'(irq_seen), 64'd1);
        if (obs_addr.size() == 4) check("retrig_addr3", 64'(obs_addr[3]), 64'h4300);

        // Watchdog timeout then recovery
        clear_obs();
        start_run(2, 32'h5000, 1'b0, 1'b0, -1);
        wait_cyc(TOUT + 1);
        check("tout_err_during", 64'({busy, err}), 64'b10);
        wait_cyc(1);
        check("tout_busy_after", 64'(busy), 64'd0);
        check("tout_err_after", 64'(err), 64'd1);
        check("tout_layer_done", 64'(layer_done), 64'd0);
        wait_idle(50);
        check("tout_irqs", 64'(irq_seen), 64'd0);
        clear_obs();
        start_run(1, 32'h6000, 1'b0, 1'b1, 1);
        check("recover_err_clear", 64'(err), 64'd0);
        wait_idle(50);
        check("recover_layer_done", 64'({layer_done, last_layer, err}), 64'b110);
        check("recover_irqs", 64'(irq_seen), 64'd1);

        // Address wrap
        clear_obs();
        start_run(2, 32'hFFFFFF00, 1'b1, 1'b0, 1);
        wait_idle(50);
        check("wrap_nstarts", 64'(obs_addr.size()), 64'd2);
        if (obs_addr.size() == 2) begin
            check("wrap_addr0", 64'(obs_addr[0]), 64'hFFFFFF00);
            check("wrap_addr1", 64'(obs_addr[1]), 64'h0);
        end

        // Reset mid-run during WAIT of tile 2, trigger held high through reset
        clear_obs();
        start_run(4, 32'h7000, 1'b1, 1'b1, 2);
        read_trigger = 1'b1;
        wait_cyc(7);
        #2;
        HRESETn = 1'b0;
        exp_q.delete();
        irq_q.delete();
        bf = 1; bt = 0; due = -1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_start", 64'(eng_if.eng_start), 64'd0);
        check("mid_rst_idx", 64'(eng_if.eng_tile_idx), 64'd0);
        check("mid_rst_addr", 64'(eng_if.eng_addr), 64'd0);
        check("mid_rst_relu", 64'(eng_if.eng_relu), 64'd0);
        check("mid_rst_flags", 64'({done_irq, layer_done, last_layer, err}), 64'd0);
        wait_cyc(2);
        num_tiles = 8'd2; base_addr = 32'h8000; is_relu = 1'b1; is_last = 1'b0;
        resp_lat = 2;
        clear_obs();
        HRESETn = 1'b1;
        predict(cyc, 2, 32'h8000, 1'b1, 2);
        wait_idle(100);
        read_trigger = 1'b0;
        check("post_rst_nstarts", 64'(obs_addr.size()), 64'd2);
        if (obs_addr.size() == 2) begin
            check("post_rst_idx0", 64'(obs_idx[0]), 64'd0);
            check("post_rst_addr0", 64'(obs_addr[0]), 64'h8000);
        end
        check("post_rst_irqs", 64'(irq_seen), 64'd1);
        wait_cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
